store_buffer: RTL and testbench

Write-side buffer between the pipemips memory stage and data memory. It accepts word stores from the core in one cycle, so the core never stalls on a slow memory write. Stores drain in order to memory through a request/acknowledge handshake. Loads issued while stores are still pending are forwarded from the buffer, and a sync request drains the buffer completely before the core continues.

---
 rtl/store_buffer_pkg.sv | 24 ++
 rtl/store_buffer_fwd_match.sv | 34 +++
 rtl/store_buffer.sv | 118 +++++++++++
 tb/tb_store_buffer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer: FSM states, the entry
// layout {word address, data} and the pointer-width helper.
package sb_pkg;

  // Entry widths; store_buffer's AW/DW parameters default to these and must match.
  localparam int SB_AW = 32;
  localparam int SB_DW = 32;

  typedef enum logic {
    SB_RUN  = 1'b0,
    SB_SYNC = 1'b1
  } sb_state_e;

  typedef struct packed {
    logic [SB_AW-3:0] waddr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  // Head/tail pointer width for a power-of-two depth.
  function automatic int SB_PTR_W(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/store_buffer_fwd_match.sv
// Load-forwarding comparators with youngest-match priority over the valid
// window [head, head+count). Compiled only when STORE_BUFFER_FWD_EN is defined.
`ifdef STORE_BUFFER_FWD_EN
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = SB_PTR_W(DEPTH)
) (
  input  sb_entry_t        entries [DEPTH],
  input  logic [PW-1:0]    head,
  input  logic [PW:0]      count,
  input  logic [SB_AW-3:0] ld_waddr,
  output logic             hit,
  output logic [SB_DW-1:0] data
);

  // Walk entries oldest to youngest; a later match overrides an earlier one.
  always_comb begin
    logic [PW-1:0] idx;
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) && (entries[idx].waddr == ld_waddr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule
`endif

// File: rtl/store_buffer.sv
// Write-side store buffer: circular FIFO of word stores draining to data
// memory over mem_we/mem_ack, with a RUN/SYNC drain state machine.
// Optional load forwarding is compiled in with `define STORE_BUFFER_FWD_EN.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  input  logic [AW-1:0]          st_addr,
  input  logic [DW-1:0]          st_data,
  output logic                   st_ready,
  input  logic [AW-1:0]          ld_addr,
  output logic                   ld_hit,
  output logic [DW-1:0]          ld_data,
  input  logic                   sync_req,
  output logic                   sync_done,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_ack,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = SB_PTR_W(DEPTH);
  localparam int CW = PW + 1;

  sb_state_e     state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  sb_entry_t     entry_q [DEPTH];
  sb_entry_t     entry_d;
  sb_entry_t     head_e;
  logic          enq, deq;

  // Address low bits are byte offsets within the word and are never used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  assign enq    = st_valid && st_ready;
  assign deq    = mem_we && mem_ack;
  assign head_e = entry_q[head_q];

  // Pointer and occupancy next-state; a dequeue can only happen when count > 0.
  always_comb begin
    head_d  = deq ? head_q + 1'b1 : head_q;
    tail_d  = enq ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CW'(enq) - CW'(deq);
    entry_d = '{waddr: st_addr[AW-1:2], data: st_data};
  end

  // Control state: async active-low reset clears pointers, count and FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SB_RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is data only and is not reset; occupancy qualifies it.
  always_ff @(posedge clk) begin
    if (enq) entry_q[tail_q] <= entry_d;
  end

  // FSM next state: a sampled sync_req enters SYNC, which exits once empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_RUN:  if (sync_req) state_d = SB_SYNC;
      SB_SYNC: if (count_q == '0) state_d = SB_RUN;
      default: state_d = SB_RUN;
    endcase
  end

  // FSM outputs depend on registered state only, never on st_valid/mem_ack/sync_req.
  always_comb begin
    st_ready  = (state_q == SB_RUN) && (count_q != CW'(DEPTH));
    sync_done = (state_q == SB_SYNC) && (count_q == '0);
  end

  // Drain port presents the head entry; zeroed while the buffer is empty.
  always_comb begin
    mem_we    = (count_q != '0);
    mem_addr  = mem_we ? {head_e.waddr, 2'b00} : '0;
    mem_wdata = mem_we ? head_e.data : '0;
    count     = count_q;
  end

`ifdef STORE_BUFFER_FWD_EN
  sb_fwd_match #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_fwd (
    .entries  (entry_q),
    .head     (head_q),
    .count    (count_q),
    .ld_waddr (ld_addr[AW-1:2]),
    .hit      (ld_hit),
    .data     (ld_data)
  );
`else
  assign ld_hit  = 1'b0;
  assign ld_data = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: accepted stores push their expected
// memory write; a negedge monitor pops and compares every mem handshake.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        sync_req;
  logic        sync_done;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb_q [$];

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .ld_addr   (ld_addr),
    .ld_hit    (ld_hit),
    .ld_data   (ld_data),
    .sync_req  (sync_req),
    .sync_done (sync_done),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, output bit acc);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    acc      = st_ready;
    if (acc) sb_q.push_back({a[31:2], 2'b00, d});
    tick();
    st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while (count != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, count, 3'd0);
  endtask

  // Monitor: every accepted memory write must match the oldest expected store.
  always @(negedge clk) begin
    if (rst && mem_we && mem_ack) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", mem_addr, mem_wdata);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          errors++;
          $display("FAIL mem_write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   mem_addr, mem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    bit acc;
    int pulses;
    rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_addr = '0; sync_req = 1'b0; mem_ack = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_st_ready", st_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_count", count, 0);
    chk("rst_sync_done", sync_done, 0);
    chk("rst_ld_hit", ld_hit, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ld_data", ld_data, 0);
    rst = 1'b1;
    tick();

    // Basic drain: one store, ack held high
    mem_ack = 1'b1;
    do_store(32'h10, 32'd5, acc);
    chk("basic_acc", acc, 1);
    chk("basic_mem_we", mem_we, 1);
    chk("basic_count1", count, 1);
    tick();
    chk("basic_count0", count, 0);
    chk("basic_mem_we0", mem_we, 0);

    // Fill with backpressure
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_store(32'h100 + 32'(4*i), 32'hA0 + 32'(i), acc);
      chk("fill_acc", acc, 1);
    end
    chk("fill_st_ready", st_ready, 0);
    chk("fill_count", count, 4);
    st_valid = 1'b1; st_addr = 32'h110; st_data = 32'hA4;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("fill_after_ack_count", count, 3);
    chk("fill_after_ack_ready", st_ready, 1);
    sb_q.push_back({32'h110, 32'hA4});
    tick();
    st_valid = 1'b0;
    chk("fill_5th_count", count, 4);
    mem_ack = 1'b1;
    wait_empty("fill_drain", 20);
    mem_ack = 1'b0;

    // Forwarding
    do_store(32'h20, 32'd1, acc);
    do_store(32'h20, 32'd2, acc);
    ld_addr = 32'h22;
    #1;
`ifdef STORE_BUFFER_FWD_EN
    chk("fwd_hit", ld_hit, 1);
    chk("fwd_data", ld_data, 2);
`else
    chk("fwd_hit_off", ld_hit, 0);
    chk("fwd_data_off", ld_data, 0);
`endif
    ld_addr = 32'h24;
    #1;
    chk("fwd_miss", ld_hit, 0);
    ld_addr = 32'h40;
    st_valid = 1'b1; st_addr = 32'h40; st_data = 32'd9;
    sb_q.push_back({32'h40, 32'd9});
    #1;
    chk("fwd_same_cycle_invisible", ld_hit, 0);
    tick();
    st_valid = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
    chk("fwd_new_hit", ld_hit, 1);
    chk("fwd_new_data", ld_data, 9);
`else
    chk("fwd_new_hit_off", ld_hit, 0);
`endif
    ld_addr = 32'h20;
    mem_ack = 1'b1;
    #1;
`ifdef STORE_BUFFER_FWD_EN
    chk("fwd_inflight_hit", ld_hit, 1);
    chk("fwd_inflight_data", ld_data, 2);
`else
    chk("fwd_inflight_off", ld_hit, 0);
`endif
    wait_empty("fwd_drain", 20);
    mem_ack = 1'b0;
    #1;
    chk("fwd_empty_miss", ld_hit, 0);

    // Sync with 3 pending, ack every other cycle; a blocked store is offered throughout
    for (int i = 0; i < 3; i++) do_store(32'h200 + 32'(4*i), 32'hB0 + 32'(i), acc);
    chk("sync_count3", count, 3);
    sync_req = 1'b1;
    tick();
    st_valid = 1'b1; st_addr = 32'h300; st_data = 32'hDEAD;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (sync_req) chk("sync_st_ready", st_ready, 0);
      if (sync_done) begin
        pulses++;
        chk("sync_done_count", count, 0);
        sync_req = 1'b0;
        st_valid = 1'b0;
      end
      mem_ack = (c % 2) == 1;
      tick();
    end
    st_valid = 1'b0; sync_req = 1'b0; mem_ack = 1'b0;
    chk("sync_pulses", pulses, 1);
    chk("sync_ready_back", st_ready, 1);

    // Sync on an already empty buffer
    sync_req = 1'b1;
    tick();
    chk("sync_empty_done", sync_done, 1);
    sync_req = 1'b0;
    tick();
    chk("sync_empty_done_clear", sync_done, 0);
    chk("sync_empty_ready", st_ready, 1);

    // Wrap-around: ten stores each overlapping an ack
    mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_store(32'h400 + 32'(4*i), 32'(i), acc);
      chk("wrap_acc", acc, 1);
      chk("wrap_count_le1", count, 1);
    end
    tick();
    chk("wrap_count_end", count, 0);
    mem_ack = 1'b0;

    // Reset mid-drain
    do_store(32'h500, 32'h55, acc);
    do_store(32'h504, 32'h66, acc);
    chk("rstmid_count2", count, 2);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_mem_we", mem_we, 0);
    chk("rstmid_count", count, 0);
    sb_q.delete();
    tick();
    rst = 1'b1;
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstmid_no_stale", mem_we, 0);
    end
    mem_ack = 1'b0;

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
